// File: rtl/round_robin_arbiter4_pkg.sv
// Shared arbiter definitions: state encoding, owner index width and one-hot helper.
// Reused by the 4-way arbiter and later N-way arbiters.
package round_robin_arbiter4_pkg;

  localparam int unsigned ArbWays   = 4;
  localparam int unsigned ArbOwnerW = 2;

  typedef logic [ArbOwnerW-1:0] arb_owner_t;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

  function automatic logic [ArbWays-1:0] arb_onehot(input arb_owner_t idx);
    logic [ArbWays-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rotate_priority4.sv
// Combinational search for the first asserted request starting at ptr and
// wrapping through ptr+1, ptr+2, ptr+3 (mod 4).
module rotate_priority4
  import round_robin_arbiter4_pkg::*;
(
  input  logic [3:0] i_request,
  input  arb_owner_t i_ptr,
  output logic       o_found,
  output arb_owner_t o_index
);

  logic [7:0] w_dbl;
  logic [3:0] w_rot;
  arb_owner_t w_off;

  // Doubling the vector turns the wrap-around into a plain slice.
  assign w_dbl = {i_request, i_request};
  assign w_rot = w_dbl[i_ptr +: 4];

  always_comb begin
    w_off = 2'd0;
    if (w_rot[0])      w_off = 2'd0;
    else if (w_rot[1]) w_off = 2'd1;
    else if (w_rot[2]) w_off = 2'd2;
    else               w_off = 2'd3;
  end

  assign o_found = |i_request;
  assign o_index = i_ptr + w_off;

endmodule

// File: rtl/round_robin_arbiter4.sv
// 4-way round-robin arbiter with registered one-hot grants, zero-bubble handover
// on release and optional timeout preemption of a long-holding owner.
module round_robin_arbiter4
  import round_robin_arbiter4_pkg::*;
#(
  parameter int unsigned timeout = 0,
  parameter int unsigned cwidth  = 8
) (
  input  logic       clk,
  input  logic       rst_x,
  input  logic       i_request0,
  input  logic       i_request1,
  input  logic       i_request2,
  input  logic       i_request3,
  output logic       o_grant0,
  output logic       o_grant1,
  output logic       o_grant2,
  output logic       o_grant3,
  output logic       o_valid,
  output logic [1:0] o_owner,
  output logic       o_preempt
);

  localparam bit              TimeoutEn   = (timeout != 0);
  localparam logic [cwidth-1:0] TimeoutLast = cwidth'((timeout == 0) ? 0 : timeout - 1);
  localparam logic [cwidth-1:0] CntMax      = '1;

  arb_state_e        r_state;
  arb_owner_t        r_ptr;
  arb_owner_t        r_owner;
  logic [cwidth-1:0] r_cnt;
  logic [3:0]        r_grant;
  logic              r_valid;
  logic              r_preempt;

  logic [3:0] w_req;
  logic [3:0] w_next_req;
  logic       w_owner_req;
  logic       w_timeout_hit;
  arb_owner_t w_next_ptr;
  logic       w_idle_found;
  arb_owner_t w_idle_idx;
  logic       w_next_found;
  arb_owner_t w_next_idx;

  assign w_req         = {i_request3, i_request2, i_request1, i_request0};
  assign w_owner_req   = w_req[r_owner];
  assign w_next_ptr    = r_owner + 2'd1;
  // Owner is masked so a handover can never land back on it.
  assign w_next_req    = w_req & ~arb_onehot(r_owner);
  assign w_timeout_hit = TimeoutEn && (r_cnt == TimeoutLast);

  rotate_priority4 u_search_idle (
    .i_request (w_req),
    .i_ptr     (r_ptr),
    .o_found   (w_idle_found),
    .o_index   (w_idle_idx)
  );

  rotate_priority4 u_search_next (
    .i_request (w_next_req),
    .i_ptr     (w_next_ptr),
    .o_found   (w_next_found),
    .o_index   (w_next_idx)
  );

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_state   <= StIdle;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (w_idle_found) begin
            r_state <= StBusy;
            r_grant <= arb_onehot(w_idle_idx);
            r_owner <= w_idle_idx;
            r_valid <= 1'b1;
          end
        end
        StBusy: begin
          if (!w_owner_req || w_timeout_hit) begin
            r_cnt <= '0;
            if (w_next_found) begin
              r_grant   <= arb_onehot(w_next_idx);
              r_owner   <= w_next_idx;
              r_ptr     <= w_next_ptr;
              // A release that coincides with timeout is still a release.
              r_preempt <= w_owner_req;
            end else if (!w_owner_req) begin
              r_state <= StIdle;
              r_grant <= '0;
              r_owner <= '0;
              r_valid <= 1'b0;
              r_ptr   <= w_next_ptr;
            end
          end else if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + cwidth'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_grant0  = r_grant[0];
  assign o_grant1  = r_grant[1];
  assign o_grant2  = r_grant[2];
  assign o_grant3  = r_grant[3];
  assign o_valid   = r_valid;
  assign o_owner   = r_owner;
  assign o_preempt = r_preempt;

endmodule

// File: tb/tb_round_robin_arbiter4.sv
// Scoreboard bench: dut_a runs without timeout, dut_b with timeout=4; expected
// grants are queued as each request pattern is driven and compared after the edge.
module tb_round_robin_arbiter4;

  logic       clk = 1'b0;
  logic       rst_x = 1'b1;
  logic [3:0] req_v = 4'b0000;

  logic       a_g0, a_g1, a_g2, a_g3, a_valid, a_preempt;
  logic [1:0] a_owner;
  logic       b_g0, b_g1, b_g2, b_g3, b_valid, b_preempt;
  logic [1:0] b_owner;
  logic [3:0] g_a, g_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit         sel;
    logic [3:0] grant;
    logic       preempt;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  round_robin_arbiter4 #(.timeout(0), .cwidth(8)) dut_a (
    .clk        (clk),
    .rst_x      (rst_x),
    .i_request0 (req_v[0]),
    .i_request1 (req_v[1]),
    .i_request2 (req_v[2]),
    .i_request3 (req_v[3]),
    .o_grant0   (a_g0),
    .o_grant1   (a_g1),
    .o_grant2   (a_g2),
    .o_grant3   (a_g3),
    .o_valid    (a_valid),
    .o_owner    (a_owner),
    .o_preempt  (a_preempt)
  );

  round_robin_arbiter4 #(.timeout(4), .cwidth(8)) dut_b (
    .clk        (clk),
    .rst_x      (rst_x),
    .i_request0 (req_v[0]),
    .i_request1 (req_v[1]),
    .i_request2 (req_v[2]),
    .i_request3 (req_v[3]),
    .o_grant0   (b_g0),
    .o_grant1   (b_g1),
    .o_grant2   (b_g2),
    .o_grant3   (b_g3),
    .o_valid    (b_valid),
    .o_owner    (b_owner),
    .o_preempt  (b_preempt)
  );

  assign g_a = {a_g3, a_g2, a_g1, a_g0};
  assign g_b = {b_g3, b_g2, b_g1, b_g0};

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc4(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Grants must stay one-hot or zero in every cycle, on both instances.
  always @(negedge clk) begin
    check_eq("onehot_a", 8'($onehot0(g_a)), 8'd1);
    check_eq("onehot_b", 8'($onehot0(g_b)), 8'd1);
  end

  task automatic compare_head();
    exp_t       e;
    logic [3:0] g;
    logic       v, p;
    logic [1:0] o;
    e = sb.pop_front();
    g = e.sel ? g_b : g_a;
    v = e.sel ? b_valid : a_valid;
    o = e.sel ? b_owner : a_owner;
    p = e.sel ? b_preempt : a_preempt;
    check_eq(e.sel ? "grant_b" : "grant_a", 8'(g), 8'(e.grant));
    check_eq(e.sel ? "valid_b" : "valid_a", 8'(v), 8'(|e.grant));
    check_eq(e.sel ? "owner_b" : "owner_a", 8'(o), 8'(enc4(e.grant)));
    check_eq(e.sel ? "preempt_b" : "preempt_a", 8'(p), 8'(e.preempt));
  endtask

  task automatic step(input bit sel, input logic [3:0] req, input logic [3:0] exp_g,
                      input logic exp_p);
    exp_t e;
    @(negedge clk);
    req_v     = req;
    e.sel     = sel;
    e.grant   = exp_g;
    e.preempt = exp_p;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  // Outputs must clear asynchronously, before any clock edge.
  task automatic apply_reset();
    rst_x = 1'b0;
    req_v = 4'b0000;
    #1;
    check_eq("rst_grant_a", 8'(g_a), 8'd0);
    check_eq("rst_valid_a", 8'(a_valid), 8'd0);
    check_eq("rst_owner_a", 8'(a_owner), 8'd0);
    check_eq("rst_preempt_a", 8'(a_preempt), 8'd0);
    check_eq("rst_grant_b", 8'(g_b), 8'd0);
    check_eq("rst_valid_b", 8'(b_valid), 8'd0);
    repeat (2) @(negedge clk);
    rst_x = 1'b1;
  endtask

  initial begin
    #2;
    apply_reset();

    // First grant from reset, then zero-bubble handover on release.
    step(0, 4'b1010, 4'b0010, 0);
    step(0, 4'b1001, 4'b1000, 0);
    step(0, 4'b0000, 4'b0000, 0);
    step(0, 4'b0000, 4'b0000, 0);

    // All four requesting, each owner releases after two cycles.
    step(0, 4'b1111, 4'b0001, 0);
    step(0, 4'b1111, 4'b0001, 0);
    step(0, 4'b1110, 4'b0010, 0);
    step(0, 4'b1111, 4'b0010, 0);
    step(0, 4'b1101, 4'b0100, 0);
    step(0, 4'b1111, 4'b0100, 0);
    step(0, 4'b1011, 4'b1000, 0);
    step(0, 4'b1111, 4'b1000, 0);
    step(0, 4'b0111, 4'b0001, 0);
    step(0, 4'b0000, 4'b0000, 0);

    // Reset mid-grant, then regrant; later check the pointer returns to 0.
    step(0, 4'b0100, 4'b0100, 0);
    #2;
    apply_reset();
    step(0, 4'b0100, 4'b0100, 0);
    step(0, 4'b0000, 4'b0000, 0);
    apply_reset();
    step(0, 4'b1001, 4'b0001, 0);
    step(0, 4'b0000, 4'b0000, 0);

    // Timeout preemption alternating between two constant requesters.
    apply_reset();
    repeat (4) step(1, 4'b0011, 4'b0001, 0);
    step(1, 4'b0011, 4'b0010, 1);
    repeat (3) step(1, 4'b0011, 4'b0010, 0);
    step(1, 4'b0011, 4'b0001, 1);
    step(1, 4'b0000, 4'b0000, 0);

    // Lone requester keeps its grant through timeouts, no preempt pulse.
    repeat (10) step(1, 4'b0001, 4'b0001, 0);
    step(1, 4'b0000, 4'b0000, 0);

    // Owner drops exactly on its timeout edge: plain release.
    repeat (4) step(1, 4'b0011, 4'b0010, 0);
    step(1, 4'b0001, 4'b0001, 0);
    step(1, 4'b0000, 4'b0000, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
